// File: rtl/ides_word_aligner_if.sv
// Word aligner bus: deserialised words and slip/auto controls in,
// framed words and alignment status out.
interface ides_word_aligner_if #(
    parameter int WIDTH = 4
);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             VALID_I;
    logic [WIDTH-1:0] D_I;
    logic             SLIP_I;
    logic             AUTO_I;
    logic             VALID_O;
    logic [WIDTH-1:0] Q_O;
    logic [PW-1:0]    PTR_O;
    logic             LOCKED_O;
    logic             FAIL_O;

    modport slave (
        input  VALID_I, D_I, SLIP_I, AUTO_I,
        output VALID_O, Q_O, PTR_O, LOCKED_O, FAIL_O
    );

    modport master (
        output VALID_I, D_I, SLIP_I, AUTO_I,
        input  VALID_O, Q_O, PTR_O, LOCKED_O, FAIL_O
    );
endinterface

// File: rtl/ides_word_aligner.sv
// Bit-slip word aligner: barrel shift over {previous, current} word with
// manual slip or automatic training-pattern search, lock and loss-of-lock.
module ides_word_aligner #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] PATTERN    = 4'b1100,
    parameter int               LOCK_COUNT = 8,
    parameter int               LOSS_COUNT = 4
) (
    input logic                CLK,
    input logic                RESETN,
    ides_word_aligner_if.slave bus
);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(LOSS_COUNT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEARCH = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_LOCK   = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    logic [2:0]       st_q, st_d;
    logic [WIDTH-1:0] hist_q, hist_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             vo_q, vo_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    tries_q, tries_d;
    logic [CW-1:0]    mc_q, mc_d;
    logic [MW-1:0]    miss_q, miss_d;
    logic             lk_q, lk_d;
    logic             fl_q, fl_d;

    logic [2*WIDTH-1:0] win;
    logic [WIDTH-1:0]   sel;
    logic [PW-1:0]      ptr_inc;
    logic               match;

    // MSB is the oldest bit, so a larger offset reaches further into history
    assign win     = {hist_q, bus.D_I};
    assign sel     = win[{1'b0, ptr_q} +: WIDTH];
    assign match   = (sel == PATTERN);
    assign ptr_inc = (ptr_q == PW'(WIDTH - 1)) ? '0 : ptr_q + 1'b1;

    always_comb begin
        st_d    = st_q;
        hist_d  = hist_q;
        q_d     = q_q;
        vo_d    = 1'b0;
        ptr_d   = ptr_q;
        tries_d = tries_q;
        mc_d    = mc_q;
        miss_d  = miss_q;
        lk_d    = lk_q;
        fl_d    = fl_q;

        if (bus.VALID_I) begin
            hist_d = bus.D_I;
            q_d    = sel;
            vo_d   = 1'b1;
        end

        unique case (st_q)
            S_IDLE: begin
                if (bus.AUTO_I) begin
                    st_d    = S_SEARCH;
                    tries_d = '0;
                    mc_d    = '0;
                end else if (bus.SLIP_I) begin
                    ptr_d = ptr_inc;
                end
            end
            S_SEARCH: begin
                if (!bus.AUTO_I) begin
                    st_d = S_IDLE;
                end else if (bus.VALID_I) begin
                    if (match) begin
                        if (mc_q != CW'(LOCK_COUNT)) mc_d = mc_q + 1'b1;
                        if (mc_q >= CW'(LOCK_COUNT - 1)) begin
                            st_d   = S_LOCK;
                            lk_d   = 1'b1;
                            miss_d = '0;
                        end
                    end else if (tries_q == PW'(WIDTH - 1)) begin
                        st_d = S_FAIL;
                        fl_d = 1'b1;
                    end else begin
                        ptr_d   = ptr_inc;
                        tries_d = tries_q + 1'b1;
                        mc_d    = '0;
                        st_d    = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (!bus.AUTO_I) st_d = S_IDLE;
                else if (bus.VALID_I) st_d = S_SEARCH;
            end
            S_LOCK: begin
                if (bus.AUTO_I) begin
                    if (bus.VALID_I) begin
                        if (match) begin
                            miss_d = '0;
                        end else begin
                            if (miss_q != MW'(LOSS_COUNT)) miss_d = miss_q + 1'b1;
                            if (miss_q >= MW'(LOSS_COUNT - 1)) begin
                                st_d    = S_SEARCH;
                                lk_d    = 1'b0;
                                tries_d = '0;
                                mc_d    = '0;
                            end
                        end
                    end
                end else if (bus.SLIP_I) begin
                    ptr_d = ptr_inc;
                    lk_d  = 1'b0;
                    st_d  = S_IDLE;
                end
            end
            S_FAIL: begin
                if (!bus.AUTO_I) begin
                    st_d = S_IDLE;
                    fl_d = 1'b0;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            st_q    <= S_IDLE;
            hist_q  <= '0;
            q_q     <= '0;
            vo_q    <= 1'b0;
            ptr_q   <= '0;
            tries_q <= '0;
            mc_q    <= '0;
            miss_q  <= '0;
            lk_q    <= 1'b0;
            fl_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            hist_q  <= hist_d;
            q_q     <= q_d;
            vo_q    <= vo_d;
            ptr_q   <= ptr_d;
            tries_q <= tries_d;
            mc_q    <= mc_d;
            miss_q  <= miss_d;
            lk_q    <= lk_d;
            fl_q    <= fl_d;
        end
    end

    assign bus.VALID_O  = vo_q;
    assign bus.Q_O      = q_q;
    assign bus.PTR_O    = ptr_q;
    assign bus.LOCKED_O = lk_q;
    assign bus.FAIL_O   = fl_q;
endmodule

// File: tb/tb_ides_word_aligner.sv
// Random and scenario stimulus on two aligner widths, each checked
// cycle by cycle against a behavioural model.
module tb_ides_word_aligner;
    localparam int W4 = 4, P4 = 'b1100, L4 = 8, S4 = 4;
    localparam int W5 = 5, P5 = 'b11000, L5 = 3, S5 = 2;
    localparam int M_IDLE = 0, M_SEARCH = 1, M_SETTLE = 2, M_LOCK = 3, M_FAIL = 4;

    typedef struct {
        int st; int ptr; int tries; int mc; int miss;
        int hist; int q; bit vo; bit lk; bit fl;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;
    mdl_t m4, m5;

    always #5 clk = ~clk;

    ides_word_aligner_if #(.WIDTH(W4)) b4 ();
    ides_word_aligner_if #(.WIDTH(W5)) b5 ();

    ides_word_aligner #(
        .WIDTH(W4), .PATTERN(4'b1100), .LOCK_COUNT(L4), .LOSS_COUNT(S4)
    ) u4 (.CLK(clk), .RESETN(rst_n), .bus(b4.slave));

    ides_word_aligner #(
        .WIDTH(W5), .PATTERN(5'b11000), .LOCK_COUNT(L5), .LOSS_COUNT(S5)
    ) u5 (.CLK(clk), .RESETN(rst_n), .bus(b5.slave));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mzero();
        mdl_t z;
        z = '{default: 0};
        return z;
    endfunction

    // Next state of the aligner from the behaviour rules, using arithmetic
    // on integers for the {hist, data} window.
    function automatic mdl_t mstep(mdl_t m, int w, int pat, int lc, int sc,
                                   bit v, int d, bit slip, bit au);
        mdl_t n;
        int   win, sel, nxt;
        bit   hit;
        n   = m;
        win = m.hist * (1 << w) + d;
        sel = (win >> m.ptr) % (1 << w);
        hit = (sel == pat);
        nxt = (m.ptr + 1) % w;
        n.vo = v;
        if (v) begin
            n.hist = d;
            n.q    = sel;
        end
        if (m.st == M_IDLE) begin
            if (au) begin
                n.st = M_SEARCH; n.tries = 0; n.mc = 0;
            end else if (slip) n.ptr = nxt;
        end else if (m.st == M_SEARCH) begin
            if (!au) n.st = M_IDLE;
            else if (v && hit) begin
                n.mc = m.mc + 1;
                if (n.mc >= lc) begin
                    n.st = M_LOCK; n.lk = 1; n.miss = 0;
                end
            end else if (v && m.tries == w - 1) begin
                n.st = M_FAIL; n.fl = 1;
            end else if (v) begin
                n.ptr = nxt; n.tries = m.tries + 1; n.mc = 0; n.st = M_SETTLE;
            end
        end else if (m.st == M_SETTLE) begin
            if (!au) n.st = M_IDLE;
            else if (v) n.st = M_SEARCH;
        end else if (m.st == M_LOCK) begin
            if (au && v) begin
                n.miss = hit ? 0 : m.miss + 1;
                if (n.miss >= sc) begin
                    n.st = M_SEARCH; n.lk = 0; n.tries = 0; n.mc = 0;
                end
            end else if (!au && slip) begin
                n.ptr = nxt; n.lk = 0; n.st = M_IDLE;
            end
        end else begin
            if (!au) begin
                n.st = M_IDLE; n.fl = 0;
            end
        end
        return n;
    endfunction

    function automatic int rot(int p, int k, int w);
        return ((p << k) | (p >> (w - k))) & ((1 << w) - 1);
    endfunction

    task automatic cmp_all();
        chk("vo4", b4.VALID_O, m4.vo);
        chk("q4", b4.Q_O, m4.q);
        chk("ptr4", b4.PTR_O, m4.ptr);
        chk("lk4", b4.LOCKED_O, m4.lk);
        chk("fl4", b4.FAIL_O, m4.fl);
        chk("vo5", b5.VALID_O, m5.vo);
        chk("q5", b5.Q_O, m5.q);
        chk("ptr5", b5.PTR_O, m5.ptr);
        chk("lk5", b5.LOCKED_O, m5.lk);
        chk("fl5", b5.FAIL_O, m5.fl);
    endtask

    task automatic cyc(input bit v, input int d4, input int d5,
                       input bit slip, input bit au);
        @(negedge clk);
        rst_n     = 1'b1;
        b4.VALID_I = v; b4.D_I = d4[3:0]; b4.SLIP_I = slip; b4.AUTO_I = au;
        b5.VALID_I = v; b5.D_I = d5[4:0]; b5.SLIP_I = slip; b5.AUTO_I = au;
        m4 = mstep(m4, W4, P4, L4, S4, v, d4 & 15, slip, au);
        m5 = mstep(m5, W5, P5, L5, S5, v, d5 & 31, slip, au);
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    // Asserted between edges; released at the next drive point.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m4 = mzero();
        m5 = mzero();
        cmp_all();
    endtask

    initial begin
        bit au, rnd;
        int ph4, ph5;
        b4.VALID_I = 0; b4.D_I = 0; b4.SLIP_I = 0; b4.AUTO_I = 0;
        b5.VALID_I = 0; b5.D_I = 0; b5.SLIP_I = 0; b5.AUTO_I = 0;
        m4 = mzero();
        m5 = mzero();
        #2;
        do_reset();

        // reset mid-stream
        repeat (3) cyc(1, 'hF, 'h1F, 0, 0);
        chk("q4_pre_rst", b4.Q_O, 'hF);
        b4.SLIP_I = 1;
        do_reset();
        chk("rst_q", b4.Q_O, 0);
        chk("rst_vo", b4.VALID_O, 0);
        chk("rst_ptr", b4.PTR_O, 0);
        chk("rst_lk", b4.LOCKED_O, 0);
        b4.SLIP_I = 0;

        // manual slip
        repeat (3) cyc(1, 'b1100, 'b11000, 0, 0);
        chk("man_q0", b4.Q_O, 'b1100);
        cyc(1, 'b1100, 'b11000, 1, 0);
        cyc(1, 'b1100, 'b11000, 0, 0);
        chk("man_ptr1", b4.PTR_O, 1);
        chk("man_q1", b4.Q_O, 'b0110);
        repeat (3) cyc(1, 'b1100, 'b11000, 1, 0);
        cyc(1, 'b1100, 'b11000, 0, 0);
        chk("man_ptr0", b4.PTR_O, 0);
        chk("man_q2", b4.Q_O, 'b1100);

        // auto lock: two mismatching offsets then eight matches
        repeat (12) cyc(1, 'b0011, 'b00011, 0, 1);
        chk("lock_early", b4.LOCKED_O, 0);
        cyc(1, 'b0011, 'b00011, 0, 1);
        chk("lock_lk", b4.LOCKED_O, 1);
        chk("lock_ptr", b4.PTR_O, 2);
        chk("lock_fl", b4.FAIL_O, 0);

        // loss of lock
        repeat (3) cyc(1, 'b1111, 'b00011, 0, 1);
        cyc(1, 'b0011, 'b00011, 0, 1);
        chk("loss_hold", b4.LOCKED_O, 1);
        repeat (3) cyc(1, 'b1111, 'b00011, 0, 1);
        chk("loss_3", b4.LOCKED_O, 1);
        cyc(1, 'b1111, 'b00011, 0, 1);
        chk("loss_4", b4.LOCKED_O, 0);
        repeat (7) cyc(1, 'b0011, 'b00011, 0, 1);
        chk("relock_early", b4.LOCKED_O, 0);
        cyc(1, 'b0011, 'b00011, 0, 1);
        chk("relock_lk", b4.LOCKED_O, 1);
        chk("relock_ptr", b4.PTR_O, 2);

        // fail: leave lock by slip, return ptr to 0, search constant zero
        cyc(1, 0, 0, 1, 0);
        chk("unlock_ptr", b4.PTR_O, 3);
        chk("unlock_lk", b4.LOCKED_O, 0);
        cyc(1, 0, 0, 1, 0);
        repeat (7) cyc(1, 0, 0, 0, 1);
        chk("fail_early", b4.FAIL_O, 0);
        cyc(1, 0, 0, 0, 1);
        chk("fail_fl", b4.FAIL_O, 1);
        chk("fail_ptr", b4.PTR_O, 3);
        chk("fail_lk", b4.LOCKED_O, 0);
        repeat (3) cyc(1, 0, 0, 1, 1);
        chk("fail_frozen", b4.PTR_O, 3);
        cyc(1, 0, 0, 0, 0);
        chk("fail_clr", b4.FAIL_O, 0);
        cyc(1, 0, 0, 1, 0);
        chk("idle_slip", b4.PTR_O, 0);

        // gaps and ptr wrap on the 5-bit aligner
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc((i % 2) == 0, $urandom_range(0, 15), $urandom_range(0, 31), 0, 0);
            chk("gap_vo5", b5.VALID_O, (i % 2) == 0);
        end
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 0, $urandom_range(0, 31), 1, 0);
            chk("wrap_ptr5", b5.PTR_O, i % 5);
        end

        // randomized traffic
        au = 0; rnd = 0; ph4 = 0; ph5 = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) au = ~au;
            if ($urandom_range(0, 99) < 4) rnd = ~rnd;
            if ($urandom_range(0, 199) == 0) begin
                ph4 = $urandom_range(0, 3);
                ph5 = $urandom_range(0, 4);
            end
            if ($urandom_range(0, 999) < 2) do_reset();
            cyc($urandom_range(0, 9) < 8,
                rnd ? $urandom_range(0, 15) : rot(P4, ph4, W4),
                rnd ? $urandom_range(0, 31) : rot(P5, ph5, W5),
                $urandom_range(0, 19) == 0, au);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
